knn_nn_engine: RTL and testbench
================================

// Module: knn_nn_engine
// PURPOSE
//  1-nearest-neighbour classifier (Manhattan distance) driven by the NIOS2 KNN PIO exports.
//  Consumes knn_dados_* / knn_treinamento from nios2_sopc and feeds knn_classe_prevista_* back.
//  Training mode stores samples in on-chip RAM; query mode scans all stored samples and returns the nearest class.
// PARAMETERS
//  N_ATTR     4    features per sample (attribute indices 0..N_ATTR-1)
//  MAX_TRAIN  64   training-sample capacity
//  VAL_W      16   feature value width (unsigned)
//  CLASS_W    16   class label width
//  CLASS_IDX  8'hFF  attribute index carrying class label (train) / query start (query)
//  DIST_W  = VAL_W+$clog2(N_ATTR)  distance accumulator width (localparam)
// PORTS
//  clk50            in   1        system clock (same domain as nios2_sopc)
//  reset            in   1        asynchronous, active-high reset
//  sw_clear         in   1        synchronous clear from knn_reset_io (level, high = clear)
//  dados_atributo   in   8        attribute index of current word
//  dados_valor      in   VAL_W    value for that attribute (class label when index = CLASS_IDX)
//  dados_pronto     in   1        software strobe; rising edge = capture event
//  treinamento      in   1        1 = training mode, 0 = query mode, sampled at capture event
//  classe_prevista  out  CLASS_W  predicted class
//  classe_pronto    out  1        result-valid level
//  busy             out  1        scan in progress
//  train_count      out  7        samples stored, 0..MAX_TRAIN
//  overflow         out  1        sticky: training sample dropped because memory full
//  err_busy         out  1        sticky: capture event arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0, staging/query regs 0, FSM IDLE. RAM contents not cleared, count=0 makes them invalid.
//  Capture event: dados_pronto high this edge and low previous edge (edge-detect register, no sync: same clock).
//  Event with index < N_ATTR: value latched into staging[idx] (train) or query[idx] (query); classe_pronto -> 0.
//  Event with index >= N_ATTR and != CLASS_IDX: ignored, no state change.
//  Train, index = CLASS_IDX: if count<MAX_TRAIN, staging[0..N_ATTR-1] and label written at slot count
//   (N_ATTR feature writes + 1 label write, done in parallel via word-wide RAM), count++ on same edge;
//   if count=MAX_TRAIN, write dropped, overflow <= 1.
//  Query, index = CLASS_IDX: start scan; busy <= 1 on the capture edge, classe_pronto <= 0.
//  FSM: IDLE -> (start, count>0) FETCH -> ACC -> CMP -> FETCH (next sample) | DONE -> IDLE.
//   IDLE  : wait for event. Start with count=0 -> DONE directly (classe_prevista=0).
//   FETCH : issue RAM read of sample i (sync read, 1-cycle latency); acc <= 0, j <= 0.
//   ACC   : acc += |query[j]-sample[i][j]| one attribute per cycle, N_ATTR cycles; abs diff VAL_W bits, zero-extend.
//   CMP   : if i==0 or acc < best (strict): best <= acc, best_class <= label[i]; tie keeps lower index.
//   DONE  : classe_prevista <= best_class, classe_pronto <= 1, busy <= 0.
//  Latency: classe_pronto rises count*(N_ATTR+2)+1 edges after the start capture edge; count=0 -> 1 edge.
//  classe_pronto holds high (and classe_prevista stable) until the next accepted capture event, sw_clear or reset.
//  Capture events while busy: ignored entirely, err_busy <= 1. Query registers unchanged during scan.
//  treinamento change during scan: no effect on scan in progress.
//  sw_clear (any state): FSM -> IDLE, count=0, busy=0, classe_pronto=0, overflow=0, err_busy=0; takes priority over
//   a simultaneous capture event (event dropped). classe_prevista retains value.
//  Reset mid-scan: immediate return to reset values; no partial result emitted.
//  No arithmetic overflow: DIST_W holds N_ATTR*(2^VAL_W-1).
// TESTING
//  T1 train {10,20,30,40}/class 3 and {100,100,100,100}/class 7, query {12,18,33,41} -> class 3, train_count=2,
//     classe_pronto exactly 2*6+1=13 edges after start edge.
//  T2 query with count=0 -> classe_prevista=0, classe_pronto 1 edge after start, busy pulse 1 cycle.
//  T3 two samples equidistant (dist 8) classes 5 then 9 -> class 5 (earliest wins tie).
//  T4 write 65 samples -> train_count=64, overflow=1; query matching sample 63 exactly -> its class, dist 0.
//  T5 start query, pulse dados_pronto mid-scan and toggle treinamento -> result unchanged, err_busy=1.
//  T6 sw_clear mid-scan and reset mid-scan -> busy=0, classe_pronto=0, train_count=0 next edge; query -> class 0.
//  Values 0xFFFF vs 0x0000 on all 4 attrs -> distance 0x3FFFC, no wrap (checked via single-sample best).

Source files
------------

// File: rtl/knn_nn_engine.sv
// 1-nearest-neighbour classifier (Manhattan distance) fed by the NIOS2 KNN PIO exports.
// Training words build a sample in staging registers; a class-index word commits it or starts a scan.
module knn_nn_engine #(
    parameter int          N_ATTR    = 4,
    parameter int          MAX_TRAIN = 64,
    parameter int          VAL_W     = 16,
    parameter int          CLASS_W   = 16,
    parameter logic [7:0]  CLASS_IDX = 8'hFF
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               sw_clear,
    input  logic [7:0]         dados_atributo,
    input  logic [VAL_W-1:0]   dados_valor,
    input  logic               dados_pronto,
    input  logic               treinamento,
    output logic [CLASS_W-1:0] classe_prevista,
    output logic               classe_pronto,
    output logic               busy,
    output logic [6:0]         train_count,
    output logic               overflow,
    output logic               err_busy
);

    localparam int DIST_W = VAL_W + $clog2(N_ATTR);
    localparam int IDX_W  = (MAX_TRAIN > 1) ? $clog2(MAX_TRAIN) : 1;
    localparam int J_W    = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
    localparam int WORD_W = CLASS_W + N_ATTR * VAL_W;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACC, S_CMP, S_DONE} state_t;

    state_t state, state_nx;

    logic                pronto_d;
    logic                cap_evt, evt_attr, evt_class, accept, busy_evt;
    logic                start, train_wr, train_ovf, last_attr, last_sample;
    logic [J_W-1:0]      attr_idx;
    logic [VAL_W-1:0]    staging [N_ATTR];
    logic [VAL_W-1:0]    query   [N_ATTR];
    logic [WORD_W-1:0]   mem     [MAX_TRAIN];
    logic [WORD_W-1:0]   wr_word, sample_q;
    logic [IDX_W-1:0]    i;
    logic [J_W-1:0]      j;
    logic [DIST_W-1:0]   acc, best;
    logic [CLASS_W-1:0]  best_class;
    logic [VAL_W-1:0]    qv, sv, absdiff;

    // Capture decode: events are accepted only in IDLE; anything arriving during a scan is flagged.
    always_comb begin
        cap_evt     = dados_pronto & ~pronto_d;
        evt_attr    = dados_atributo < 8'(N_ATTR);
        evt_class   = dados_atributo == CLASS_IDX;
        attr_idx    = dados_atributo[J_W-1:0];
        accept      = cap_evt & ~sw_clear & (state == S_IDLE) & (evt_attr | evt_class);
        busy_evt    = cap_evt & ~sw_clear & (state != S_IDLE);
        start       = accept & evt_class & ~treinamento;
        train_wr    = accept & evt_class & treinamento & (train_count < 7'(MAX_TRAIN));
        train_ovf   = accept & evt_class & treinamento & (train_count == 7'(MAX_TRAIN));
        last_attr   = j == J_W'(N_ATTR - 1);
        last_sample = (7'(i) + 7'd1) == train_count;
    end

    always_comb begin
        wr_word = '0;
        for (int unsigned k = 0; k < N_ATTR; k++)
            wr_word[k*VAL_W +: VAL_W] = staging[k];
        wr_word[N_ATTR*VAL_W +: CLASS_W] = dados_valor;
    end

    always_comb begin
        qv      = query[j];
        sv      = sample_q[j*VAL_W +: VAL_W];
        absdiff = (qv >= sv) ? (qv - sv) : (sv - qv);
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset)         state <= S_IDLE;
        else if (sw_clear) state <= S_IDLE;
        else               state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (train_count == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_nx = S_ACC;
            S_ACC:   if (last_attr) state_nx = S_CMP;
            S_CMP:   state_nx = last_sample ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = state != S_IDLE;
    end

    // Sample RAM: one word per sample, features and label written together; no reset by design.
    always_ff @(posedge clk50) begin
        if (train_wr)
            mem[train_count[IDX_W-1:0]] <= wr_word;
        if (state == S_FETCH)
            sample_q <= mem[i];
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            pronto_d        <= 1'b0;
            train_count     <= '0;
            overflow        <= 1'b0;
            err_busy        <= 1'b0;
            classe_pronto   <= 1'b0;
            classe_prevista <= '0;
            i               <= '0;
            j               <= '0;
            acc             <= '0;
            best            <= '0;
            best_class      <= '0;
            for (int unsigned k = 0; k < N_ATTR; k++) begin
                staging[k] <= '0;
                query[k]   <= '0;
            end
        end else begin
            pronto_d <= dados_pronto;
            if (sw_clear) begin
                train_count   <= '0;
                overflow      <= 1'b0;
                err_busy      <= 1'b0;
                classe_pronto <= 1'b0;
            end else begin
                if (busy_evt)
                    err_busy <= 1'b1;
                if (accept) begin
                    classe_pronto <= 1'b0;
                    if (evt_attr) begin
                        if (treinamento) staging[attr_idx] <= dados_valor;
                        else             query[attr_idx]   <= dados_valor;
                    end
                end
                if (train_wr)
                    train_count <= train_count + 7'd1;
                if (train_ovf)
                    overflow <= 1'b1;
                if (start) begin
                    i          <= '0;
                    best       <= '0;
                    best_class <= '0;
                end
                case (state)
                    S_FETCH: begin
                        acc <= '0;
                        j   <= '0;
                    end
                    S_ACC: begin
                        acc <= acc + DIST_W'(absdiff);
                        j   <= j + J_W'(1);
                    end
                    // Strict compare keeps the earliest sample on a tie.
                    S_CMP: begin
                        if (i == '0 || acc < best) begin
                            best       <= acc;
                            best_class <= sample_q[N_ATTR*VAL_W +: CLASS_W];
                        end
                        if (!last_sample)
                            i <= i + IDX_W'(1);
                    end
                    S_DONE: begin
                        classe_prevista <= best_class;
                        classe_pronto   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_knn_nn_engine.sv
// Self-checking bench for knn_nn_engine: directed scenarios plus random training sets and queries,
// checked against a plain nearest-neighbour model over the list of stored samples.
module tb_knn_nn_engine;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        sw_clear = 1'b0;
    logic [7:0]  dados_atributo = '0;
    logic [15:0] dados_valor = '0;
    logic        dados_pronto = 1'b0;
    logic        treinamento = 1'b0;
    logic [15:0] classe_prevista;
    logic        classe_pronto;
    logic        busy;
    logic [6:0]  train_count;
    logic        overflow;
    logic        err_busy;

    knn_nn_engine #(.N_ATTR(4), .MAX_TRAIN(64), .VAL_W(16), .CLASS_W(16), .CLASS_IDX(8'hFF)) dut (
        .clk50(clk50), .reset(reset), .sw_clear(sw_clear),
        .dados_atributo(dados_atributo), .dados_valor(dados_valor),
        .dados_pronto(dados_pronto), .treinamento(treinamento),
        .classe_prevista(classe_prevista), .classe_pronto(classe_pronto), .busy(busy),
        .train_count(train_count), .overflow(overflow), .err_busy(err_busy)
    );

    always #10 clk50 = ~clk50;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [15:0] m_feat [64][4];
    logic [15:0] m_cls  [64];
    int          m_count = 0;
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] mq [4];
    logic [15:0] m_last = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_class();
        int best = -1;
        logic [15:0] bc = '0;
        for (int s = 0; s < m_count; s++) begin
            int d = 0;
            for (int a = 0; a < 4; a++) begin
                int x = int'(m_feat[s][a]) - int'(mq[a]);
                d += (x < 0) ? -x : x;
            end
            if (best < 0 || d < best) begin
                best = d;
                bc = m_cls[s];
            end
        end
        return bc;
    endfunction

    task automatic pulse(input logic [7:0] idx, input logic [15:0] val, input logic tr);
        @(negedge clk50);
        dados_atributo = idx; dados_valor = val; treinamento = tr; dados_pronto = 1'b1;
        @(negedge clk50);
        dados_pronto = 1'b0;
    endtask

    task automatic train_sample(input logic [3:0][15:0] f, input logic [15:0] cls);
        for (int a = 0; a < 4; a++) pulse(8'(a), f[a], 1'b1);
        pulse(8'hFF, cls, 1'b1);
        if (m_count < 64) begin
            for (int a = 0; a < 4; a++) m_feat[m_count][a] = f[a];
            m_cls[m_count] = cls;
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic send_query(input logic [3:0][15:0] q);
        for (int a = 0; a < 4; a++) begin
            pulse(8'(a), q[a], 1'b0);
            mq[a] = q[a];
        end
    endtask

    // Issues the start word, optionally injects a capture event mid-scan, waits for the result.
    task automatic start_and_check(input string tag, input bit inject);
        int n = 0;
        bit done = 0;
        logic [15:0] exp_cls = model_class();
        int exp_lat = m_count * 6 + 1;
        @(negedge clk50);
        dados_atributo = 8'hFF; dados_valor = '0; treinamento = 1'b0; dados_pronto = 1'b1;
        @(posedge clk50); #1;
        dados_pronto = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_pronto_low"}, 32'(classe_pronto), 32'd0);
        while (!done && n < 2000) begin
            @(posedge clk50); #1;
            n++;
            if (inject && n == 3) begin
                dados_atributo = 8'd0; dados_valor = 16'h1234; treinamento = 1'b1; dados_pronto = 1'b1;
            end
            if (inject && n == 4) begin
                dados_pronto = 1'b0; treinamento = 1'b0;
            end
            if (classe_pronto) done = 1;
        end
        if (inject) m_err = 1'b1;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_class"}, 32'(classe_prevista), 32'(exp_cls));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        m_last = exp_cls;
    endtask

    task automatic do_clear();
        @(negedge clk50); sw_clear = 1'b1;
        @(negedge clk50); sw_clear = 1'b0;
        m_count = 0; m_ovf = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(train_count), 32'(m_count));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_errb"}, 32'(err_busy), 32'(m_err));
    endtask

    initial begin
        logic [3:0][15:0] f;
        for (int a = 0; a < 4; a++) mq[a] = '0;
        repeat (3) @(negedge clk50);
        reset = 1'b0;
        @(negedge clk50);

        // Reset state
        check("rst_class", 32'(classe_prevista), 32'd0);
        check("rst_pronto", 32'(classe_pronto), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_status("rst");

        // T2: empty memory
        start_and_check("t2_empty", 1'b0);

        // T1: two samples
        train_sample({16'd40, 16'd30, 16'd20, 16'd10}, 16'd3);
        train_sample({16'd100, 16'd100, 16'd100, 16'd100}, 16'd7);
        send_query({16'd41, 16'd33, 16'd18, 16'd12});
        start_and_check("t1", 1'b0);
        check_status("t1");
        pulse(8'h10, 16'd5, 1'b0);
        check("t1_ignored_idx_keeps_pronto", 32'(classe_pronto), 32'd1);
        pulse(8'd0, 16'd12, 1'b0);
        mq[0] = 16'd12;
        check("t1_attr_clears_pronto", 32'(classe_pronto), 32'd0);

        // T3: tie at distance 8 keeps the earlier sample
        do_clear();
        train_sample({16'd2, 16'd2, 16'd2, 16'd2}, 16'd5);
        train_sample({16'd0, 16'd0, 16'd0, 16'd8}, 16'd9);
        send_query({16'd0, 16'd0, 16'd0, 16'd0});
        start_and_check("t3_tie", 1'b0);

        // Full-scale distance must not wrap: 0x3FFFC vs 0x1FFFE
        do_clear();
        train_sample({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'd11);
        train_sample({16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF}, 16'd12);
        send_query({16'd0, 16'd0, 16'd0, 16'd0});
        start_and_check("maxdist", 1'b0);

        // Random training sets and queries (small range provokes near-ties)
        for (int r = 0; r < 2; r++) begin
            do_clear();
            for (int s = 0; s < 5; s++) begin
                for (int a = 0; a < 4; a++) f[a] = 16'($urandom_range(0, 60));
                train_sample(f, 16'($urandom_range(1, 200)));
            end
            for (int k = 0; k < 3; k++) begin
                for (int a = 0; a < 4; a++) f[a] = 16'($urandom_range(0, 60));
                send_query(f);
                start_and_check($sformatf("rnd%0d_%0d", r, k), 1'b0);
            end
            check_status($sformatf("rnd%0d", r));
        end

        // T5: capture event and mode toggle during a scan
        start_and_check("t5_inject", 1'b1);
        check_status("t5");
        start_and_check("t5_query_regs_kept", 1'b0);

        // T4: 65 samples, overflow, exact match on slot 63
        do_clear();
        for (int s = 0; s < 65; s++) begin
            for (int a = 0; a < 4; a++) f[a] = 16'($urandom);
            train_sample(f, 16'(100 + s));
        end
        check_status("t4");
        for (int a = 0; a < 4; a++) f[a] = m_feat[63][a];
        send_query(f);
        start_and_check("t4_match63", 1'b0);

        // T6a: sw_clear mid-scan
        @(negedge clk50);
        dados_atributo = 8'hFF; treinamento = 1'b0; dados_pronto = 1'b1;
        @(negedge clk50); dados_pronto = 1'b0;
        repeat (10) @(negedge clk50);
        check("t6_busy_before_clear", 32'(busy), 32'd1);
        sw_clear = 1'b1;
        @(negedge clk50); sw_clear = 1'b0;
        m_count = 0; m_ovf = 1'b0; m_err = 1'b0;
        check("t6_clr_busy", 32'(busy), 32'd0);
        check("t6_clr_pronto", 32'(classe_pronto), 32'd0);
        check("t6_clr_class_kept", 32'(classe_prevista), 32'(m_last));
        check_status("t6_clr");
        start_and_check("t6_clr_query", 1'b0);

        // T6b: reset mid-scan
        train_sample({16'd1, 16'd2, 16'd3, 16'd4}, 16'd21);
        train_sample({16'd9, 16'd9, 16'd9, 16'd9}, 16'd22);
        @(negedge clk50);
        dados_atributo = 8'hFF; treinamento = 1'b0; dados_pronto = 1'b1;
        @(negedge clk50); dados_pronto = 1'b0;
        @(posedge clk50); #1;
        reset = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_pronto", 32'(classe_pronto), 32'd0);
        check("t6_rst_count", 32'(train_count), 32'd0);
        check("t6_rst_class", 32'(classe_prevista), 32'd0);
        @(negedge clk50); reset = 1'b0;
        m_count = 0; m_ovf = 1'b0; m_err = 1'b0;
        for (int a = 0; a < 4; a++) mq[a] = '0;
        @(negedge clk50);
        start_and_check("t6_rst_query", 1'b0);
        check_status("t6_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
